// File: rtl/bcd_to_bin_converter_pkg.sv
// bcd_to_bin_converter_pkg: shared FSM encoding, default sizes and digit-correction constants
package bcd_to_bin_converter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, FINISH = 2'd2} state_t;
  localparam int DEF_DIGITS = 6;
  localparam int DEF_BIN_W = 20;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB = 4'd3;
  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/bcd_to_bin_converter_adjust.sv
// bcd_nibble_adjust: undo the decimal carry of one BCD nibble after a right shift (n>=8 ? n-3 : n)
module bcd_nibble_adjust
  import bcd_to_bin_converter_pkg::*;
(
  input  logic [3:0] n,
  output logic [3:0] y
);
  assign y = n >= ADJ_THRESH ? n - ADJ_SUB : n;
endmodule

// File: rtl/bcd_to_bin_converter.sv
// bcd_to_bin_converter: start/done reverse double-dabble BCD-to-binary converter (clk, reset, start, bcd_in -> bin_out, busy, done, err)
module bcd_to_bin_converter
  import bcd_to_bin_converter_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]    bin_out,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W = BCD_W + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  if (BIN_W < 63 && (longint'(1) << BIN_W) <= pow10(DIGITS) - 1) begin : g_width_check
    $fatal(1, "BIN_W too narrow for DIGITS");
  end
  state_t state, state_nx;
  logic [SR_W-1:0] sr, sr_shift, sr_nx;
  logic [BCD_W-1:0] bcd_adj;
  logic [CW-1:0] cnt;
  logic bad, bad_in;
  assign sr_shift = sr >> 1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_nibble_adjust u_adj (.n(sr_shift[BIN_W+4*i +: 4]), .y(bcd_adj[4*i +: 4]));
  end
  assign sr_nx = {bcd_adj, sr_shift[BIN_W-1:0]};
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad_in = bad_in | (bcd_in[4*i +: 4] > BCD_MAX_DIGIT);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // an invalid input passes through one throw-away CONVERT cycle so its result lands two cycles after acceptance
  always_comb begin
    state_nx = state == IDLE    ? (start ? CONVERT : IDLE) :
               state == CONVERT ? ((bad || cnt == CW'(BIN_W - 1)) ? FINISH : CONVERT) :
                                  IDLE;
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (state == IDLE && start) begin
        sr  <= {bcd_in, {BIN_W{1'b0}}};
        cnt <= '0;
        bad <= bad_in;
      end
      if (state == CONVERT) begin
        sr  <= sr_nx;
        cnt <= cnt + CW'(1);
      end
      if (state == FINISH) begin
        bin_out <= bad ? '0 : sr[BIN_W-1:0];
        err     <= bad;
      end
    end
  end
endmodule
